// File: rtl/comparador_serie_lsb_if.sv
`default_nettype none
// ============================================================================
// Module   : comparador_serie_lsb_if
// Brief    : Start/operand/result bundle for the bit-serial LSB-first comparator.
// Revision : 1.0 - initial release
// ============================================================================
interface comparador_serie_lsb_if #(
    parameter int N = 4
);
    logic         inicio;
    logic [0:N-1] a;
    logic [0:N-1] b;
    logic         ocupado;
    logic         listo;
    logic         a_menor;
    logic         a_igual;
    logic         a_mayor;

    modport master (
        output inicio, a, b,
        input  ocupado, listo, a_menor, a_igual, a_mayor
    );

    modport slave (
        input  inicio, a, b,
        output ocupado, listo, a_menor, a_igual, a_mayor
    );
endinterface
`default_nettype wire

// File: rtl/comparador_serie_lsb.sv
`default_nettype none
// ============================================================================
// Module   : comparador_serie_lsb
// Brief    : Bit-serial unsigned magnitude comparator, LSB first; each more
//            significant bit overrides the verdict reached so far.
// Revision : 1.0 - initial release
// ============================================================================
module comparador_serie_lsb #(
    parameter int N = 4
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    comparador_serie_lsb_if.slave  bus
);

    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] c_ultimo = CW'(N - 1);

    typedef enum logic [0:0] {
        REPOSO  = 1'b0,
        COMPARA = 1'b1
    } estado_t;

    typedef enum logic [1:0] {
        IGUAL = 2'd0,
        MENOR = 2'd1,
        MAYOR = 2'd2
    } veredicto_t;

    estado_t      r_estado,  w_estado;
    logic [0:N-1] r_sr_a,    w_sr_a;
    logic [0:N-1] r_sr_b,    w_sr_b;
    logic [CW-1:0] r_cnt,    w_cnt;
    veredicto_t   r_ver,     w_ver;
    veredicto_t   w_ver_bit;
    logic         r_ocupado, w_ocupado;
    logic         r_listo,   w_listo;
    logic         r_menor,   w_menor;
    logic         r_igual,   w_igual;
    logic         r_mayor,   w_mayor;
    logic         w_pa, w_pb;

    always_comb begin
        w_estado  = r_estado;
        w_sr_a    = r_sr_a;
        w_sr_b    = r_sr_b;
        w_cnt     = r_cnt;
        w_ver     = r_ver;
        w_ocupado = r_ocupado;
        w_listo   = 1'b0;
        w_menor   = r_menor;
        w_igual   = r_igual;
        w_mayor   = r_mayor;

        // Bits arrive LSB first, so a differing bit always outranks the older verdict.
        w_pa = r_sr_a[N-1];
        w_pb = r_sr_b[N-1];
        if (!w_pa && w_pb)
            w_ver_bit = MENOR;
        else if (w_pa && !w_pb)
            w_ver_bit = MAYOR;
        else
            w_ver_bit = r_ver;

        case (r_estado)
            REPOSO: begin
                if (bus.inicio) begin
                    w_sr_a    = bus.a;
                    w_sr_b    = bus.b;
                    w_ver     = IGUAL;
                    w_cnt     = '0;
                    w_ocupado = 1'b1;
                    w_estado  = COMPARA;
                end
            end
            COMPARA: begin
                w_ver  = w_ver_bit;
                w_sr_a = {1'b0, r_sr_a[0:N-2]};
                w_sr_b = {1'b0, r_sr_b[0:N-2]};
                w_cnt  = r_cnt + CW'(1);
                if (r_cnt == c_ultimo) begin
                    w_menor   = (w_ver_bit == MENOR);
                    w_igual   = (w_ver_bit == IGUAL);
                    w_mayor   = (w_ver_bit == MAYOR);
                    w_listo   = 1'b1;
                    w_ocupado = 1'b0;
                    w_estado  = REPOSO;
                end
            end
            default: begin
                w_estado  = REPOSO;
                w_ocupado = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_estado  <= REPOSO;
            r_sr_a    <= '0;
            r_sr_b    <= '0;
            r_cnt     <= '0;
            r_ver     <= IGUAL;
            r_ocupado <= 1'b0;
            r_listo   <= 1'b0;
            r_menor   <= 1'b0;
            r_igual   <= 1'b0;
            r_mayor   <= 1'b0;
        end else begin
            r_estado  <= w_estado;
            r_sr_a    <= w_sr_a;
            r_sr_b    <= w_sr_b;
            r_cnt     <= w_cnt;
            r_ver     <= w_ver;
            r_ocupado <= w_ocupado;
            r_listo   <= w_listo;
            r_menor   <= w_menor;
            r_igual   <= w_igual;
            r_mayor   <= w_mayor;
        end
    end

    assign bus.ocupado = r_ocupado;
    assign bus.listo   = r_listo;
    assign bus.a_menor = r_menor;
    assign bus.a_igual = r_igual;
    assign bus.a_mayor = r_mayor;

endmodule
`default_nettype wire

// File: tb/tb_comparador_serie_lsb.sv
`default_nettype none
// ============================================================================
// Module   : tb_comparador_serie_lsb
// Brief    : Self-checking bench for comparador_serie_lsb (table, corner
//            sequences, randomized and exhaustive against an arithmetic model).
// Revision : 1.0 - initial release
// ============================================================================
module tb_comparador_serie_lsb;

    localparam int N = 4;

    typedef struct {
        logic [0:N-1] a;
        logic [0:N-1] b;
        logic [2:0]   e;   // {menor, igual, mayor}
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_vec = 0;
    int   n_err = 0;
    logic [2:0] cur;       // result flags the DUT must be holding
    vec_t tbl [12];

    comparador_serie_lsb_if #(.N(N)) bus ();

    comparador_serie_lsb #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [2:0] flags();
        return {bus.a_menor, bus.a_igual, bus.a_mayor};
    endfunction

    function automatic logic [2:0] model(input logic [0:N-1] x, input logic [0:N-1] y);
        int ux = int'(x);
        int uy = int'(y);
        return {ux < uy, ux == uy, ux > uy};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.inicio = 1'b0;
            @(posedge clk); #1;
            chk("idle_listo", 32'(bus.listo), 32'd0);
            chk("idle_ocupado", 32'(bus.ocupado), 32'd0);
            chk("idle_flags", 32'(flags()), 32'(cur));
        end
    endtask

    task automatic run_op(input logic [0:N-1] va, input logic [0:N-1] vb,
                          input logic [2:0] e, input bit noise);
        @(negedge clk);
        bus.inicio = 1'b1;
        bus.a = va;
        bus.b = vb;
        @(posedge clk); #1;
        chk("start_ocupado", 32'(bus.ocupado), 32'd1);
        chk("start_listo", 32'(bus.listo), 32'd0);
        for (int i = 1; i <= N; i++) begin
            @(negedge clk);
            bus.inicio = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.a = N'($urandom);
            bus.b = N'($urandom);
            @(posedge clk); #1;
            if (i < N) begin
                chk("scan_ocupado", 32'(bus.ocupado), 32'd1);
                chk("scan_listo", 32'(bus.listo), 32'd0);
                chk("scan_flags_steady", 32'(flags()), 32'(cur));
            end else begin
                chk("done_listo", 32'(bus.listo), 32'd1);
                chk("done_ocupado", 32'(bus.ocupado), 32'd0);
                chk("done_flags", 32'(flags()), 32'(e));
                chk("done_onehot", 32'($countones(flags())), 32'd1);
                cur = e;
            end
        end
    endtask

    initial begin
        tbl[0]  = '{4'b0011, 4'b0101, 3'b100};
        tbl[1]  = '{4'b1000, 4'b0111, 3'b001};
        tbl[2]  = '{4'b1010, 4'b1010, 3'b010};
        tbl[3]  = '{4'b0110, 4'b0110, 3'b010};
        tbl[4]  = '{4'b0101, 4'b1001, 3'b100};
        tbl[5]  = '{4'b0000, 4'b0000, 3'b010};
        tbl[6]  = '{4'b1111, 4'b0000, 3'b001};
        tbl[7]  = '{4'b0000, 4'b1111, 3'b100};
        tbl[8]  = '{4'b1111, 4'b1111, 3'b010};
        tbl[9]  = '{4'b0001, 4'b0000, 3'b001};
        tbl[10] = '{4'b0111, 4'b1000, 3'b100};
        tbl[11] = '{4'b1110, 4'b1101, 3'b001};

        rst_n      = 1'b0;
        bus.inicio = 1'b0;
        bus.a      = '0;
        bus.b      = '0;
        cur        = 3'b000;

        // Reset state, then quiet idle after release
        #12;
        chk("rst_ocupado", 32'(bus.ocupado), 32'd0);
        chk("rst_listo", 32'(bus.listo), 32'd0);
        chk("rst_flags", 32'(flags()), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(10);

        // Table vectors, applied back-to-back
        for (int t = 0; t < 12; t++)
            run_op(tbl[t].a, tbl[t].b, tbl[t].e, 1'b0);

        // Second inicio during a scan is dropped
        idle(1);
        @(negedge clk);
        bus.inicio = 1'b1; bus.a = 4'b0001; bus.b = 4'b0000;
        @(posedge clk); #1;
        chk("ign_ocupado_k", 32'(bus.ocupado), 32'd1);
        @(negedge clk);
        bus.inicio = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        bus.inicio = 1'b1; bus.a = 4'b0000; bus.b = 4'b1111;
        @(posedge clk); #1;
        chk("ign_ocupado_k2", 32'(bus.ocupado), 32'd1);
        @(negedge clk);
        bus.inicio = 1'b0;
        @(posedge clk); #1;
        chk("ign_ocupado_k3", 32'(bus.ocupado), 32'd1);
        chk("ign_listo_k3", 32'(bus.listo), 32'd0);
        @(posedge clk); #1;
        chk("ign_listo_k4", 32'(bus.listo), 32'd1);
        chk("ign_flags_k4", 32'(flags()), 32'b001);
        cur = 3'b001;
        idle(N + 2);

        // Reset in the middle of a scan
        @(negedge clk);
        bus.inicio = 1'b1; bus.a = 4'b0000; bus.b = 4'b1111;
        @(posedge clk);
        @(negedge clk);
        bus.inicio = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_ocupado", 32'(bus.ocupado), 32'd0);
        chk("abort_listo", 32'(bus.listo), 32'd0);
        chk("abort_flags", 32'(flags()), 32'd0);
        cur = 3'b000;
        @(negedge clk);
        rst_n = 1'b1;
        idle(N + 2);
        run_op(4'b0000, 4'b1111, 3'b100, 1'b0);

        // Randomized operations with inicio/operand noise during scans
        for (int r = 0; r < 60; r++) begin
            logic [0:N-1] ra, rb;
            ra = N'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? ra : N'($urandom);
            run_op(ra, rb, model(ra, rb), 1'b1);
            if ($urandom_range(0, 1) == 1)
                idle(int'($urandom_range(1, 3)));
        end

        // Exhaustive cross-check of all operand pairs
        idle(1);
        for (int x = 0; x < (1 << N); x++) begin
            for (int y = 0; y < (1 << N); y++) begin
                run_op(N'(x), N'(y), model(N'(x), N'(y)), 1'b0);
            end
        end
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
